frame_port_arbiter: RTL

//   Parametrised successor to the fixed three-port frame-buffer hookup (camera, VGA, ALU).

---
 rtl/frame_mem_pkg.sv | 19 +
 rtl/frame_port_arbiter_rr_arbiter.sv | 37 +++
 rtl/frame_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/frame_mem_pkg.sv
// Shared frame-buffer constants: default widths, frame geometry and client indices.
package frame_mem_pkg;

  localparam int FB_ADDR_W    = 19;
  localparam int FB_DATA_W    = 12;
  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  localparam int CLIENT_VGA = 0;
  localparam int CLIENT_CAM = 1;
  localparam int CLIENT_ALU = 2;

  // Index increment that wraps at n, for client-ring arithmetic.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/frame_port_arbiter_rr_arbiter.sv
// N-way round-robin pick: first requester at or after ptr, ignoring masked-out clients.
module rr_arbiter
  import frame_mem_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     skip,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx] && !skip[cand_idx]) begin
        gnt_valid     = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_port_arbiter.sv
// Single-port frame-buffer arbiter: fixed-priority display client, round-robin for the
// rest, starvation guard, registered BRAM command and in-order read-return tagging.
module frame_port_arbiter
  import frame_mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int RD_LAT      = 2,
  parameter int PRIO_CLIENT = CLIENT_VGA,
  parameter int MAX_STARVE  = 15
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [NUM_CLIENTS-1:0] PRIO_MASK = NUM_CLIENTS'(1) << PRIO_CLIENT;
  localparam logic [IDX_W-1:0]       RR_RESET  = IDX_W'(wrap_inc(PRIO_CLIENT, NUM_CLIENTS));

  logic [IDX_W-1:0]       rr_ptr, rr_ptr_next, rr_idx, gnt_idx;
  logic [NUM_CLIENTS-1:0] rr_gnt;
  logic                   rr_valid, other_pending, force_rr, prio_win, rr_win, any_gnt;
  logic [CNT_W-1:0]       starve_cnt;
  logic                   tag_vld [RD_LAT];
  logic [IDX_W-1:0]       tag_idx [RD_LAT];
  int                     rr_step;

  assign other_pending = |(req & ~PRIO_MASK);
  assign force_rr      = other_pending && (starve_cnt == CNT_W'(MAX_STARVE));

  rr_arbiter #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req),
    .skip      (PRIO_MASK),
    .ptr       (rr_ptr),
    .gnt       (rr_gnt),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Grant is suppressed during reset so no command can be issued while rst is high.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    prio_win = 1'b0;
    rr_win   = 1'b0;
    if (!rst) begin
      if (req[PRIO_CLIENT] && !force_rr) begin
        prio_win = 1'b1;
        gnt      = PRIO_MASK;
        gnt_idx  = IDX_W'(PRIO_CLIENT);
      end else if (rr_valid) begin
        rr_win  = 1'b1;
        gnt     = rr_gnt;
        gnt_idx = rr_idx;
      end
    end
  end

  assign any_gnt = prio_win | rr_win;

  always_comb begin
    rr_step = wrap_inc(int'(rr_idx), NUM_CLIENTS);
    if (rr_step == PRIO_CLIENT) rr_step = wrap_inc(rr_step, NUM_CLIENTS);
    rr_ptr_next = IDX_W'(rr_step);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rr_ptr     <= RR_RESET;
      starve_cnt <= '0;
    end else begin
      if (rr_win) rr_ptr <= rr_ptr_next;
      if (prio_win && other_pending) begin
        if (starve_cnt != CNT_W'(MAX_STARVE)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= any_gnt;
      mem_we <= any_gnt & we[gnt_idx];
      if (any_gnt) begin
        mem_addr  <= addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        mem_wdata <= wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      end
    end
  end

  // The last tag stage lines up with mem_rdata, which is then registered with its owner.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_idx[k] <= '0;
      end
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      tag_vld[0] <= any_gnt & ~we[gnt_idx];
      tag_idx[0] <= gnt_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
      rvalid <= tag_vld[RD_LAT-1] ? (NUM_CLIENTS'(1) << tag_idx[RD_LAT-1]) : '0;
      if (tag_vld[RD_LAT-1]) rdata <= mem_rdata;
    end
  end

endmodule
